uart_tx_sched: RTL and testbench

Two-requester UART transmit scheduler for the blinky SoC: arbitrates byte requests from two on-chip sources (e.g. heartbeat/status logic and the CPU) and serialises the granted byte onto `uart_tx` as 8N1 frames. It replaces the free-running counter bit that currently drives `uart_tx`. It owns the baud divider, the framing FSM and a round-robin grant.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_tx_sched.sv | 122 ++++++++++++
 tb/tb_uart_tx_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and framing constants for the UART transmit scheduler.
package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;
endpackage

// File: rtl/uart_baud_tick.sv
// Loadable 16-bit baud down-counter; tick is high while the count sits at zero.
module uart_baud_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         run_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);

  // Holds at zero rather than wrapping; the FSM reloads it on every tick it uses.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (run_i && !tick_o) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmitter: grants one byte at a time and sends it as 8N1.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       tx_en,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic       grant_id
);
  localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   last_grant_q, last_grant_d;
  logic                   grant_id_q, grant_id_d;
  logic                   uart_tx_q, uart_tx_d;
  logic                   busy_q;
  logic                   tick, cnt_load, idle;
  logic                   elig0, elig1, gnt0, gnt1, hs0, hs1;

  uart_baud_tick #(.W(16)) u_baud (
    .clk        (clk),
    .reset_     (reset_),
    .load_i     (cnt_load),
    .load_val_i (RELOAD),
    .run_i      (!idle),
    .tick_o     (tick)
  );

  assign idle  = (state_q == ST_IDLE);
  assign elig0 = tx_en & req0_valid;
  assign elig1 = tx_en & req1_valid;
  // On a tie the requester that did not send the previous frame wins.
  assign gnt0  = elig0 & (~elig1 | last_grant_q);
  assign gnt1  = elig1 & (~elig0 | ~last_grant_q);

  assign req0_ready = reset_ & idle & gnt0;
  assign req1_ready = reset_ & idle & gnt1;
  assign hs0        = req0_ready & req0_valid;
  assign hs1        = req1_ready & req1_valid;

  // uart_tx_d is the line level for the state being entered, so the output stays registered.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    uart_tx_d    = uart_tx_q;
    cnt_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        uart_tx_d = 1'b1;
        if (hs0 || hs1) begin
          shreg_d      = hs1 ? req1_data : req0_data;
          last_grant_d = hs1;
          grant_id_d   = hs1;
          cnt_load     = 1'b1;
          uart_tx_d    = 1'b0;
          state_d      = ST_START;
        end
      end
      ST_START: if (tick) begin
        cnt_load  = 1'b1;
        bit_cnt_d = 3'd0;
        uart_tx_d = shreg_q[0];
        state_d   = ST_DATA;
      end
      ST_DATA: if (tick) begin
        cnt_load  = 1'b1;
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          uart_tx_d = 1'b1;
          state_d   = ST_STOP;
        end else begin
          uart_tx_d = shreg_q[1];
        end
      end
      ST_STOP: if (tick) begin
        uart_tx_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      uart_tx_q    <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      uart_tx_q    <= uart_tx_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign uart_tx  = uart_tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: table of single-frame vectors plus multi-frame corner sequences.
module tb_uart_tx_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_;
  logic       a_en, a_r0v, a_r1v, a_r0r, a_r1r, a_tx, a_busy, a_gid;
  logic [7:0] a_r0d, a_r1d;
  logic       b_en, b_r0v, b_r1v, b_r0r, b_r1r, b_tx, b_busy, b_gid;
  logic [7:0] b_r0d, b_r1d;

  uart_tx_sched #(.BAUD_DIV(4)) dut_a (
    .clk(clk), .reset_(reset_), .tx_en(a_en),
    .req0_valid(a_r0v), .req0_data(a_r0d), .req0_ready(a_r0r),
    .req1_valid(a_r1v), .req1_data(a_r1d), .req1_ready(a_r1r),
    .uart_tx(a_tx), .busy(a_busy), .grant_id(a_gid)
  );

  uart_tx_sched #(.BAUD_DIV(2)) dut_b (
    .clk(clk), .reset_(reset_), .tx_en(b_en),
    .req0_valid(b_r0v), .req0_data(b_r0d), .req0_ready(b_r0r),
    .req1_valid(b_r1v), .req1_data(b_r1d), .req1_ready(b_r1r),
    .uart_tx(b_tx), .busy(b_busy), .grant_id(b_gid)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       r0v;
    logic [7:0] r0d;
    logic       r1v;
    logic [7:0] r1d;
    logic       exp_gid;
    logic [7:0] exp_byte;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic get_tx(input bit s);   return s ? b_tx : a_tx; endfunction
  function automatic logic get_busy(input bit s); return s ? b_busy : a_busy; endfunction
  function automatic logic get_gid(input bit s);  return s ? b_gid : a_gid; endfunction
  function automatic logic get_rdy(input bit s);  return s ? (b_r0r | b_r1r) : (a_r0r | a_r1r); endfunction

  task automatic set_in(input bit s, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1);
    if (s) begin b_r0v = v0; b_r0d = d0; b_r1v = v1; b_r1d = d1; end
    else   begin a_r0v = v0; a_r0d = d0; a_r1v = v1; a_r1d = d1; end
  endtask

  // Call from the negedge where a ready was seen; k=0 is the negedge after the handshake edge.
  task automatic frame(input bit s, input int D,
                       input logic n0v, input logic [7:0] n0d, input logic n1v, input logic [7:0] n1d,
                       input int en_drop_k,
                       output logic gid, output logic [7:0] data,
                       output int busy_cnt, output int glitches, output int rdy_cnt);
    logic smp [0:63];
    logic e;
    int   slot;
    busy_cnt = 0; glitches = 0; rdy_cnt = 0; gid = 1'b0; data = 8'h00;
    for (int k = 0; k <= 10*D; k++) begin
      @(negedge clk);
      if (k == 0) set_in(s, n0v, n0d, n1v, n1d);
      if (k == en_drop_k) begin
        if (s) b_en = 1'b0; else a_en = 1'b0;
      end
      #1;
      smp[k] = get_tx(s);
      if (k == 0) gid = get_gid(s);
      if (k < 10*D) begin
        if (get_busy(s) === 1'b1) busy_cnt++;
        if (get_rdy(s) !== 1'b0)  rdy_cnt++;
      end else if (get_busy(s) !== 1'b0) begin
        glitches++;
      end
    end
    for (int i = 0; i < 8; i++) data[i] = smp[D*(1+i) + D/2];
    for (int k = 0; k <= 10*D; k++) begin
      slot = k / D;
      if (slot == 0)      e = 1'b0;
      else if (slot >= 9) e = 1'b1;
      else                e = smp[D*slot + D/2];
      if (smp[k] !== e) glitches++;
    end
  endtask

  logic       g;
  logic [7:0] dat;
  int         bc, gl, rc, hs, hs2, bad;

  initial begin
    vt[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5};
    vt[1] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h5A};
    vt[2] = '{1'b1, 8'h01, 1'b1, 8'h80, 1'b0, 8'h01};
    vt[3] = '{1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1, 8'h3C};
    vt[4] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF};
    vt[5] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00};
    vt[6] = '{1'b1, 8'h12, 1'b1, 8'h34, 1'b0, 8'h12};

    reset_ = 1'b0; a_en = 1'b1; b_en = 1'b1;
    set_in(0, 0, 8'h00, 0, 8'h00);
    set_in(1, 0, 8'h00, 0, 8'h00);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", a_tx, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_gid", a_gid, 0);
    @(negedge clk) reset_ = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk); #1;
      if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_r0r !== 1'b0 || a_r1r !== 1'b0 || a_gid !== 1'b0)
        bad++;
    end
    chk("idle_50_cycles", bad, 0);

    // Single-frame vectors
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_in(0, vt[i].r0v, vt[i].r0d, vt[i].r1v, vt[i].r1d);
      #1;
      chk($sformatf("v%0d_rdy0", i), a_r0r, !vt[i].exp_gid);
      chk($sformatf("v%0d_rdy1", i), a_r1r, vt[i].exp_gid);
      frame(0, 4, 0, 8'h00, 0, 8'h00, -1, g, dat, bc, gl, rc);
      chk($sformatf("v%0d_gid", i), g, vt[i].exp_gid);
      chk($sformatf("v%0d_byte", i), dat, vt[i].exp_byte);
      chk($sformatf("v%0d_busy_len", i), bc, 40);
      chk($sformatf("v%0d_line", i), gl, 0);
      chk($sformatf("v%0d_rdy_in_frame", i), rc, 0);
      chk($sformatf("v%0d_rdy_after", i), get_rdy(0), 0);
    end

    // Contention: fresh reset so req0 wins the first tie
    @(negedge clk) reset_ = 1'b0;
    @(negedge clk) reset_ = 1'b1;
    @(negedge clk);
    set_in(0, 1, 8'h11, 1, 8'h22);
    #1;
    chk("cont_first_rdy0", a_r0r, 1);
    chk("cont_first_rdy1", a_r1r, 0);
    hs = cyc + 1;
    for (int f = 0; f < 4; f++) begin
      frame(0, 4, 1, 8'h11, 1, 8'h22, -1, g, dat, bc, gl, rc);
      chk($sformatf("cont%0d_gid", f), g, f % 2);
      chk($sformatf("cont%0d_byte", f), dat, (f % 2) ? 8'h22 : 8'h11);
      chk($sformatf("cont%0d_busy_len", f), bc, 40);
      chk($sformatf("cont%0d_line", f), gl, 0);
      chk($sformatf("cont%0d_rdy_in_frame", f), rc, 0);
      if (f < 3) begin
        hs2 = cyc + 1;
        chk($sformatf("cont%0d_spacing", f), hs2 - hs, 41);
        chk($sformatf("cont%0d_next_rdy", f), (f % 2) ? a_r0r : a_r1r, 1);
        hs = hs2;
      end else begin
        set_in(0, 0, 8'h00, 0, 8'h00);
      end
    end

    // Enable gating: last grant was 1, so req0 carries 0x3C
    @(negedge clk);
    set_in(0, 1, 8'h3C, 1, 8'h99);
    #1;
    chk("en_rdy0", a_r0r, 1);
    frame(0, 4, 0, 8'h00, 1, 8'h99, 10, g, dat, bc, gl, rc);
    chk("en_byte", dat, 8'h3C);
    chk("en_gid", g, 0);
    chk("en_busy_len", bc, 40);
    chk("en_line", gl, 0);
    chk("en_rdy_in_frame", rc, 0);
    chk("en_rdy1_low_off", a_r1r, 0);
    bad = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (a_r0r !== 1'b0 || a_r1r !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    chk("en_off_hold", bad, 0);
    @(negedge clk) a_en = 1'b1;
    #1;
    chk("en_on_rdy1", a_r1r, 1);
    frame(0, 4, 0, 8'h00, 0, 8'h00, -1, g, dat, bc, gl, rc);
    chk("en_on_byte", dat, 8'h99);
    chk("en_on_gid", g, 1);

    // Reset during data bit 3 (bit 3 of 0xA5 is 0)
    @(negedge clk);
    set_in(0, 1, 8'hA5, 0, 8'h00);
    #1;
    chk("rm_rdy0", a_r0r, 1);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k == 0) set_in(0, 0, 8'h00, 0, 8'h00);
    end
    #1;
    chk("rm_pre_tx", a_tx, 0);
    chk("rm_pre_busy", a_busy, 1);
    #2 reset_ = 1'b0;
    #1;
    chk("rm_async_tx", a_tx, 1);
    chk("rm_async_busy", a_busy, 0);
    @(negedge clk);
    reset_ = 1'b1;
    set_in(0, 1, 8'h5A, 1, 8'h77);
    #1;
    chk("rm_after_rdy0", a_r0r, 1);
    chk("rm_after_rdy1", a_r1r, 0);
    frame(0, 4, 0, 8'h00, 0, 8'h00, -1, g, dat, bc, gl, rc);
    chk("rm_after_byte", dat, 8'h5A);
    chk("rm_after_gid", g, 0);
    chk("rm_after_line", gl, 0);

    // Minimum divider, back-to-back from req1
    @(negedge clk);
    set_in(1, 0, 8'h00, 1, 8'h00);
    #1;
    chk("md_rdy1", b_r1r, 1);
    hs = cyc + 1;
    frame(1, 2, 0, 8'h00, 1, 8'hFF, -1, g, dat, bc, gl, rc);
    chk("md0_byte", dat, 8'h00);
    chk("md0_gid", g, 1);
    chk("md0_busy_len", bc, 20);
    chk("md0_line", gl, 0);
    chk("md0_next_rdy1", b_r1r, 1);
    hs2 = cyc + 1;
    chk("md_spacing", hs2 - hs, 21);
    frame(1, 2, 0, 8'h00, 0, 8'h00, -1, g, dat, bc, gl, rc);
    chk("md1_byte", dat, 8'hFF);
    chk("md1_gid", g, 1);
    chk("md1_busy_len", bc, 20);
    chk("md1_line", gl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
